// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the SPI target endpoint
`timescale 1ns/1ps
package spi_pkg;

  localparam int DEF_DATA_W = 32;

  // {CPOL,CPHA} encodings
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Target FSM states
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

endpackage

// File: rtl/spi_sync_fifo.sv
// rtl/spi_sync_fifo.sv - single-clock FIFO with stream-style push and pop ports
`timescale 1ns/1ps
module spi_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign in_tready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign out_tvalid = (count_q != '0);
  // Head is read straight from storage; forced to zero while empty so nothing stale leaks out.
  assign out_tdata  = out_tvalid ? mem_q[rd_ptr_q] : '0;
  assign do_push    = in_tvalid & in_tready;
  assign do_pop     = out_tready & out_tvalid;

  // Next-state for pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_tdata;
  end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI target endpoint with synchronized pins and TX/RX FIFOs
`timescale 1ns/1ps
module spi_target
  import spi_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [4:0]        word_size,
  input  logic              clear_flags,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              busy,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  // Pin synchronizers; sclk and cs_n carry one extra flop for edge detection.
  logic [SYNC_STAGES:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES:0]   cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic sclk_s, sclk_p, cs_s, cs_p, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  // FSM and datapath registers
  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [4:0]        ws_q, ws_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic              miso_q, miso_d;
  logic              rx_overrun_q, rx_overrun_d;
  logic              tx_underrun_q, tx_underrun_d;

  // FIFO handshakes and per-cycle control
  logic [DATA_W-1:0] tx_head, load_word;
  logic              tx_avail, tx_pop;
  logic              rx_push, rx_can_push;
  logic              ovr_set, und_set;
  logic              cpol, cpha, lead_edge, trail_edge, sample_edge, shift_edge;
  logic              abort, word_done;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sclk_p    = sclk_sync_q[SYNC_STAGES];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign cs_p      = cs_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p;
  assign sclk_fall = ~sclk_s & sclk_p;
  assign cs_fall   = ~cs_s & cs_p;
  assign cs_rise   = cs_s & ~cs_p;

  assign busy        = ~cs_s & enable;
  assign miso_oe     = busy;
  assign miso        = miso_q;
  assign rx_overrun  = rx_overrun_q;
  assign tx_underrun = tx_underrun_q;

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (tx_data),
    .in_tvalid  (tx_valid),
    .in_tready  (tx_ready),
    .out_tdata  (tx_head),
    .out_tvalid (tx_avail),
    .out_tready (tx_pop)
  );

  spi_sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk        (clk),
    .reset      (reset),
    .in_tdata   (rx_sh_q),
    .in_tvalid  (rx_push),
    .in_tready  (rx_can_push),
    .out_tdata  (rx_data),
    .out_tvalid (rx_valid),
    .out_tready (rx_ready)
  );

  // Shift each pin into its synchronizer chain.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-1:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-1:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  // Decode the latched mode into sample and shift edges.
  always_comb begin
    cpol = 1'b0;
    cpha = 1'b0;
    case (mode_q)
      MODE0:   begin cpol = 1'b0; cpha = 1'b0; end
      MODE1:   begin cpol = 1'b0; cpha = 1'b1; end
      MODE2:   begin cpol = 1'b1; cpha = 1'b0; end
      MODE3:   begin cpol = 1'b1; cpha = 1'b1; end
      default: begin cpol = 1'b0; cpha = 1'b0; end
    endcase
    lead_edge   = cpol ? sclk_fall : sclk_rise;
    trail_edge  = cpol ? sclk_rise : sclk_fall;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
  end

  // Transfer FSM: IDLE waits for select, LOAD fetches a TX word, SHIFT moves bits both ways.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    ws_d      = ws_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    rx_sh_d   = rx_sh_q;
    miso_d    = miso_q;
    load_word = '0;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    ovr_set   = 1'b0;
    und_set   = 1'b0;
    abort     = cs_rise | ~enable;
    word_done = (bit_cnt_q == CNT_W'(ws_q) + CNT_W'(1));
    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && enable) begin
          mode_d  = mode;
          ws_d    = word_size;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (tx_avail) begin
            load_word = tx_head;
            tx_pop    = 1'b1;
          end else begin
            und_set   = 1'b1;
          end
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          // CPHA=0 presents the MSB immediately; CPHA=1 waits for the first shift edge.
          if (!cpha) begin
            miso_d = load_word[ws_q];
            sh_d   = load_word << 1;
          end else begin
            sh_d   = load_word;
          end
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (word_done) begin
          rx_push = 1'b1;
          ovr_set = ~rx_can_push;
          state_d = LOAD;
        end else begin
          if (sample_edge) begin
            rx_sh_d   = {rx_sh_q[DATA_W-2:0], mosi_s};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          // In CPHA=0 the trailing edge left over from the previous word must not eat the new MSB.
          if (shift_edge && (cpha || bit_cnt_q != '0)) begin
            miso_d = sh_q[ws_q];
            sh_d   = sh_q << 1;
          end
        end
      end
      default: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
    rx_overrun_d  = (rx_overrun_q & ~clear_flags) | ovr_set;
    tx_underrun_d = (tx_underrun_q & ~clear_flags) | und_set;
  end

  // All control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      state_q       <= IDLE;
      mode_q        <= MODE0;
      ws_q          <= '0;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      rx_sh_q       <= '0;
      miso_q        <= 1'b0;
      rx_overrun_q  <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      state_q       <= state_d;
      mode_q        <= mode_d;
      ws_q          <= ws_d;
      bit_cnt_q     <= bit_cnt_d;
      sh_q          <= sh_d;
      rx_sh_q       <= rx_sh_d;
      miso_q        <= miso_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - directed self-checking bench for spi_target
`timescale 1ns/1ps
module tb_spi_target;

  localparam int H = 80;

  logic        clk, reset, enable, clear_flags;
  logic [1:0]  mode;
  logic [4:0]  word_size;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic        rx_overrun, tx_underrun, busy;
  logic        sclk, cs_n, mosi, miso, miso_oe;
  logic [31:0] mi;
  int          total, bad;

  spi_target dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .word_size   (word_size),
    .clear_flags (clear_flags),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_overrun  (rx_overrun),
    .tx_underrun (tx_underrun),
    .busy        (busy),
    .sclk        (sclk),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tx_push(input logic [31:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic rx_pop();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  task automatic cs_low(input logic [1:0] m, input logic [4:0] ws);
    mode      = m;
    word_size = ws;
    sclk      = m[1];
    #(H);
    cs_n = 1'b0;
    #(H);
  endtask

  task automatic cs_high();
    #(H);
    cs_n = 1'b1;
    #(2 * H);
  endtask

  // Master side of one word: drives mosi MSB-first and captures miso on its sample edge.
  task automatic bus_word(input logic [1:0] m, input int nb, input logic [31:0] mo,
                          output logic [31:0] got);
    got = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      if (!m[0]) begin
        mosi = mo[i];
        #(H);
        sclk = ~m[1];
        got  = {got[30:0], miso};
        #(H);
        sclk = m[1];
      end else begin
        sclk = ~m[1];
        mosi = mo[i];
        #(H);
        sclk = m[1];
        got  = {got[30:0], miso};
        #(H);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; enable = 1'b1; clear_flags = 1'b0;
    mode = 2'b00; word_size = 5'd7;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_outs", {rx_data[27:0], rx_overrun, tx_underrun, busy, miso}, 32'd0);

    // 1: mode 0, 8-bit word
    tx_push(32'hA5);
    cs_low(2'b00, 5'd7);
    chk("t1_busy", {30'd0, busy, miso_oe}, 32'd3);
    bus_word(2'b00, 8, 32'h3C, mi);
    chk("t1_miso", mi, 32'hA5);
    chk("t1_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("t1_rx_data", rx_data, 32'h3C);
    chk("t1_overrun", {31'd0, rx_overrun}, 32'd0);
    cs_high();
    chk("t1_idle_miso", {30'd0, miso, busy}, 32'd0);
    rx_pop();

    // 2: mode 3, two back-to-back 32-bit words
    tx_push(32'hDEADBEEF);
    tx_push(32'h01234567);
    cs_low(2'b11, 5'd31);
    bus_word(2'b11, 32, 32'h12345678, mi);
    chk("t2_miso0", mi, 32'hDEADBEEF);
    bus_word(2'b11, 32, 32'h9ABCDEF0, mi);
    chk("t2_miso1", mi, 32'h01234567);
    cs_high();
    chk("t2_rx0", rx_data, 32'h12345678);
    rx_pop();
    chk("t2_rx1", rx_data, 32'h9ABCDEF0);
    rx_pop();
    chk("t2_rx_empty", {31'd0, rx_valid}, 32'd0);

    // 3: empty TX FIFO -> zeros and underrun
    pulse_clear();
    chk("t3_und_pre", {31'd0, tx_underrun}, 32'd0);
    cs_low(2'b00, 5'd7);
    bus_word(2'b00, 8, 32'h55, mi);
    chk("t3_miso", mi, 32'h0);
    chk("t3_underrun", {31'd0, tx_underrun}, 32'd1);
    cs_high();
    chk("t3_rx", rx_data, 32'h55);
    rx_pop();
    pulse_clear();
    chk("t3_cleared", {31'd0, tx_underrun}, 32'd0);

    // 4: RX full then one more word
    cs_low(2'b00, 5'd7);
    for (int i = 0; i < 16; i++) bus_word(2'b00, 8, 32'(i), mi);
    chk("t4_ovr_pre", {31'd0, rx_overrun}, 32'd0);
    chk("t4_full", {31'd0, rx_valid}, 32'd1);
    bus_word(2'b00, 8, 32'hEE, mi);
    chk("t4_overrun", {31'd0, rx_overrun}, 32'd1);
    cs_high();
    for (int i = 0; i < 16; i++) begin
      chk("t4_data", rx_data, 32'(i));
      rx_pop();
    end
    chk("t4_drained", {31'd0, rx_valid}, 32'd0);
    pulse_clear();
    chk("t4_cleared", {30'd0, rx_overrun, tx_underrun}, 32'd0);

    // 5: abort after 5 bits, then a clean word
    tx_push(32'h81);
    cs_low(2'b00, 5'd7);
    bus_word(2'b00, 5, 32'h1F, mi);
    cs_high();
    chk("t5_no_push", {31'd0, rx_valid}, 32'd0);
    tx_push(32'h5A);
    cs_low(2'b00, 5'd7);
    bus_word(2'b00, 8, 32'hC3, mi);
    chk("t5_miso", mi, 32'h5A);
    cs_high();
    chk("t5_rx", rx_data, 32'hC3);
    rx_pop();

    // 6: reset mid-word, then a clean word
    tx_push(32'h77);
    tx_push(32'h11);
    cs_low(2'b00, 5'd7);
    bus_word(2'b00, 4, 32'hA, mi);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("t6_rst_outs", {rx_data[26:0], rx_valid, miso, miso_oe, busy, tx_underrun}, 32'd0);
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    tx_push(32'h96);
    cs_low(2'b00, 5'd7);
    bus_word(2'b00, 8, 32'h69, mi);
    chk("t6_miso", mi, 32'h96);
    cs_high();
    chk("t6_rx", rx_data, 32'h69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
